// File: rtl/mips_cp0_if.sv
// Signal bundle between the MIPS pipeline and coprocessor 0.
// The pipeline side drives exception state and mtc0 traffic; CP0 returns the request, EPC and read data.
interface mips_cp0_if;
  logic [31:0] instr;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] din;
  logic [31:0] PC;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        WE;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] dout;

  modport master (
    output instr, A1, A2, din, PC, ExcCode, HWInt, WE, EXLSet, EXLClr,
    input  IntReq, EPC, dout
  );

  modport slave (
    input  instr, A1, A2, din, PC, ExcCode, HWInt, WE, EXLSet, EXLClr,
    output IntReq, EPC, dout
  );
endinterface

// File: rtl/mips_cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception request, and the mfc0/mtc0 port.
// Exception entry takes priority over eret and over any coincident mtc0.
module mips_cp0 (
  input logic        clk,
  input logic        reset,
  mips_cp0_if.slave  cp0
);
  localparam logic [31:0] PRID = 32'h2018_1202;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_bd_now;
  logic        w_interrupt;
  logic        w_exception;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_pc_aligned;
  logic        w_unused;

  assign w_op         = cp0.instr[31:26];
  assign w_funct      = cp0.instr[5:0];
  assign w_pc_aligned = {cp0.PC[31:2], 2'b00};
  assign w_unused     = ^{cp0.instr[25:6], cp0.PC[1:0]};

  // The write-back instruction is a branch or jump, so the faulting one sits in its delay slot.
  always_comb begin
    w_bd_now = 1'b0;
    case (w_op)
      6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: w_bd_now = 1'b1;
      6'h00: w_bd_now = (w_funct == 6'h08) || (w_funct == 6'h09);
      default: w_bd_now = 1'b0;
    endcase
  end

  assign w_interrupt = (|(cp0.HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exception = (cp0.ExcCode != 5'd0) & ~r_exl;
  assign cp0.IntReq  = ~reset & (w_interrupt | w_exception);

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};

  assign cp0.EPC = reset ? 32'd0 : r_epc;

  always_comb begin
    cp0.dout = 32'd0;
    if (reset) begin
      cp0.dout = (cp0.A1 == 5'd15) ? PRID : 32'd0;
    end else begin
      case (cp0.A1)
        5'd12:   cp0.dout = w_sr;
        5'd13:   cp0.dout = w_cause;
        5'd14:   cp0.dout = r_epc;
        5'd15:   cp0.dout = PRID;
        default: cp0.dout = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= cp0.HWInt;
      if (cp0.EXLSet) begin
        r_exl     <= 1'b1;
        r_bd      <= w_bd_now;
        r_exccode <= w_interrupt ? 5'd0 : cp0.ExcCode;
        r_epc     <= w_bd_now ? (w_pc_aligned - 32'd4) : w_pc_aligned;
      end else begin
        if (cp0.EXLClr) begin
          r_exl <= 1'b0;
        end
        if (cp0.WE && (cp0.A2 == 5'd12)) begin
          r_im  <= cp0.din[15:10];
          r_exl <= cp0.din[1];
          r_ie  <= cp0.din[0];
        end
        if (cp0.WE && (cp0.A2 == 5'd14)) begin
          r_epc <= {cp0.din[31:2], 2'b00};
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_cp0.sv
// Bench for mips_cp0: directed scenarios, then random traffic against a register-word model.
// EXLSet is tied to the model's request except where a scenario forces it.
module tb_mips_cp0;
  localparam logic [31:0] PRID = 32'h2018_1202;
  localparam logic [31:0] ADDU = 32'h0022_1821;
  localparam logic [31:0] BEQ  = 32'h1022_0003;
  localparam int TIED = 2;

  logic clk = 1'b0;
  logic reset;
  mips_cp0_if bus();

  mips_cp0 dut (
    .clk   (clk),
    .reset (reset),
    .cp0   (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] mSr    = 32'd0;
  logic [31:0] mCause = 32'd0;
  logic [31:0] mEpc   = 32'd0;
  logic [31:0] insTab [11];

  function automatic logic isBranch(input logic [31:0] ins);
    return ((ins[31:26] >= 6'd1) && (ins[31:26] <= 6'd7)) ||
           ((ins[31:26] == 6'd0) && ((ins[5:0] == 6'd8) || (ins[5:0] == 6'd9)));
  endfunction

  function automatic logic modelIrq();
    return (((32'(bus.HWInt) << 10) & mSr & 32'h0000_FC00) != 32'd0) && mSr[0] && !mSr[1];
  endfunction

  function automatic logic modelReq();
    if (reset) return 1'b0;
    return modelIrq() || ((bus.ExcCode != 5'd0) && !mSr[1]);
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (reset) return (a == 5'd15) ? PRID : 32'd0;
    case (a)
      5'd12:   return mSr;
      5'd13:   return mCause;
      5'd14:   return mEpc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".IntReq"}, {31'd0, bus.IntReq}, {31'd0, modelReq()});
    checkValue({tag, ".EPC"}, bus.EPC, reset ? 32'd0 : mEpc);
    checkValue({tag, ".dout"}, bus.dout, modelRead(bus.A1));
  endtask

  task automatic modelEdge();
    logic [31:0] ip;
    logic irq;
    logic bd;
    if (reset) begin
      mSr = 32'd0; mCause = 32'd0; mEpc = 32'd0;
    end else begin
      ip  = 32'(bus.HWInt) << 10;
      irq = modelIrq();
      bd  = isBranch(bus.instr);
      if (bus.EXLSet) begin
        mSr    = mSr | 32'd2;
        mCause = (bd ? 32'h8000_0000 : 32'd0) | ip | (irq ? 32'd0 : (32'(bus.ExcCode) << 2));
        mEpc   = (bus.PC & ~32'd3) - (bd ? 32'd4 : 32'd0);
      end else begin
        mCause = (mCause & ~32'h0000_FC00) | ip;
        if (bus.EXLClr) mSr = mSr & ~32'd2;
        if (bus.WE && bus.A2 == 5'd12) mSr = bus.din & 32'h0000_FC03;
        if (bus.WE && bus.A2 == 5'd14) mEpc = bus.din & ~32'd3;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic [31:0] ins,
                               input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] d,
                               input logic [31:0] pc, input logic [4:0] exc, input logic [5:0] hw,
                               input logic we, input int set, input logic clr);
    reset = rst; bus.instr = ins; bus.A1 = a1; bus.A2 = a2; bus.din = d; bus.PC = pc;
    bus.ExcCode = exc; bus.HWInt = hw; bus.WE = we; bus.EXLClr = clr;
    bus.EXLSet = (set == TIED) ? modelReq() : (set != 0);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    insTab = '{ADDU, BEQ, 32'h1400_0002, 32'h1800_0004, 32'h1C00_0004, 32'h0400_0001,
               32'h0800_0010, 32'h0C00_0010, 32'h03E0_0008, 32'h0040_F809, 32'h8C22_0000};

    // Reset: registers read back zero, PRId constant, no request despite all lines high.
    applyStimulus("rst0", 1, ADDU, 5'd15, 0, 0, 0, 0, 6'h3F, 0, 0, 0);
    checkValue("rst.prid", bus.dout, PRID);
    clockEdge();
    applyStimulus("rst1", 1, ADDU, 5'd12, 0, 0, 0, 0, 6'h3F, 0, 0, 0);
    checkValue("rst.req", {31'd0, bus.IntReq}, 32'd0);
    clockEdge();
    applyStimulus("rd13", 0, ADDU, 5'd13, 0, 0, 0, 0, 6'h00, 0, TIED, 0);
    checkValue("rst.cause", bus.dout, 32'd0);
    clockEdge();

    // Interrupt entry.
    applyStimulus("srw", 0, ADDU, 5'd14, 5'd12, 32'h0000_FC01, 0, 0, 6'h00, 1, TIED, 0);
    checkValue("rst.epc", bus.dout, 32'd0);
    clockEdge();
    applyStimulus("irq", 0, ADDU, 5'd12, 0, 0, 32'h0000_3010, 0, 6'h01, 0, TIED, 0);
    checkValue("irq.req", {31'd0, bus.IntReq}, 32'd1);
    clockEdge();
    applyStimulus("irq.after", 0, ADDU, 5'd13, 0, 0, 0, 0, 6'h01, 0, TIED, 0);
    checkValue("irq.cause", bus.dout, 32'h0000_0400);
    checkValue("irq.epc", bus.EPC, 32'h0000_3010);
    checkValue("irq.masked", {31'd0, bus.IntReq}, 32'd0);
    clockEdge();

    // Exception in a branch delay slot.
    applyStimulus("eret1", 0, ADDU, 5'd12, 0, 0, 0, 0, 6'h00, 0, TIED, 1);
    clockEdge();
    applyStimulus("exc", 0, BEQ, 5'd13, 0, 0, 32'h0000_3024, 5'd4, 6'h00, 0, TIED, 0);
    checkValue("exc.req", {31'd0, bus.IntReq}, 32'd1);
    clockEdge();
    applyStimulus("exc.after", 0, ADDU, 5'd13, 0, 0, 0, 0, 6'h00, 0, TIED, 0);
    checkValue("exc.cause", bus.dout, 32'h8000_0010);
    checkValue("exc.epc", bus.EPC, 32'h0000_3020);
    clockEdge();

    // IE=0 masks interrupts but IP still tracks the lines; exceptions still fire.
    applyStimulus("eret2", 0, ADDU, 5'd12, 0, 0, 0, 0, 6'h00, 0, TIED, 1);
    clockEdge();
    applyStimulus("srw2", 0, ADDU, 5'd12, 5'd12, 32'h0000_FC00, 0, 0, 6'h00, 1, TIED, 0);
    clockEdge();
    applyStimulus("ie0", 0, ADDU, 5'd13, 0, 0, 0, 0, 6'h01, 0, TIED, 0);
    checkValue("ie0.req", {31'd0, bus.IntReq}, 32'd0);
    clockEdge();
    applyStimulus("ie0.exc", 0, ADDU, 5'd13, 0, 0, 32'h0000_3100, 5'd10, 6'h01, 0, TIED, 0);
    checkValue("ie0.ip", bus.dout, 32'h8000_0410);
    checkValue("ie0.excreq", {31'd0, bus.IntReq}, 32'd1);
    clockEdge();

    // eret with the interrupt held re-raises the request; EXLSet beats EXLClr.
    applyStimulus("srw3", 0, ADDU, 5'd13, 5'd12, 32'h0000_FC03, 0, 0, 6'h01, 1, TIED, 0);
    checkValue("ie0.cause", bus.dout, 32'h0000_0428);
    clockEdge();
    applyStimulus("eret3", 0, ADDU, 5'd12, 0, 0, 0, 0, 6'h01, 0, TIED, 1);
    checkValue("eret3.req", {31'd0, bus.IntReq}, 32'd0);
    clockEdge();
    applyStimulus("rearm", 0, ADDU, 5'd12, 0, 0, 32'h0000_3200, 0, 6'h01, 0, TIED, 0);
    checkValue("rearm.sr", bus.dout, 32'h0000_FC01);
    checkValue("rearm.req", {31'd0, bus.IntReq}, 32'd1);
    clockEdge();
    applyStimulus("setclr", 0, ADDU, 5'd12, 0, 0, 32'h0000_3300, 0, 6'h01, 0, 1, 1);
    clockEdge();
    applyStimulus("setclr.after", 0, ADDU, 5'd12, 0, 0, 0, 0, 6'h00, 0, TIED, 0);
    checkValue("setclr.sr", bus.dout, 32'h0000_FC03);
    clockEdge();

    // mtc0 EPC coinciding with entry is dropped; alone it lands with low bits cleared.
    applyStimulus("eret4", 0, ADDU, 5'd12, 0, 0, 0, 0, 6'h00, 0, TIED, 1);
    clockEdge();
    applyStimulus("epcw.exc", 0, ADDU, 5'd14, 5'd14, 32'h0000_4183, 32'h0000_5000, 5'd4, 6'h00, 1, TIED, 0);
    checkValue("epcw.req", {31'd0, bus.IntReq}, 32'd1);
    clockEdge();
    applyStimulus("epcw", 0, ADDU, 5'd14, 5'd14, 32'h0000_4183, 0, 0, 6'h00, 1, TIED, 0);
    checkValue("epcw.entry", bus.EPC, 32'h0000_5000);
    clockEdge();
    applyStimulus("epcw.after", 0, ADDU, 5'd14, 0, 0, 0, 0, 6'h00, 0, TIED, 0);
    checkValue("epcw.write", bus.EPC, 32'h0000_4180);
    clockEdge();

    // Random traffic; ExcCode is forced to 0 whenever a line is up, as the top level does.
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  hw;
      logic [4:0]  exc;
      logic [4:0]  a2;
      hw  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      exc = (hw == 6'd0 && $urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      case ($urandom_range(0, 4))
        0: a2 = 5'd12;
        1: a2 = 5'd13;
        2: a2 = 5'd14;
        3: a2 = 5'd15;
        default: a2 = 5'($urandom);
      endcase
      applyStimulus("rand", $urandom_range(0, 39) == 0, insTab[$urandom_range(0, 10)],
                    5'($urandom_range(10, 16)), a2, $urandom, $urandom, exc, hw,
                    $urandom_range(0, 2) == 0, TIED, $urandom_range(0, 3) == 0);
      clockEdge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/mips_cp0.md
# mips_cp0

System-control coprocessor 0 for the five-stage pipelined MIPS core. It sits beside the memory stage and holds the status (SR), cause (Cause), exception-PC (EPC) and processor-ID (PRId) registers. It raises the combinational interrupt/exception request that flushes the pipeline and redirects fetch to the handler. It also supplies EPC to fetch for `eret`, and serves `mfc0`/`mtc0` register accesses.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  instruction currently in write-back (the one preceding the memory-stage instruction); used only for branch-delay detection.
- A1  in  5  CP0 read register number (`mfc0` rd field).
- A2  in  5  CP0 write register number (`mtc0` rd field).
- din  in  32  `mtc0` write data.
- PC  in  32  PC of the memory-stage instruction.
- ExcCode  in  5  exception code of the memory-stage instruction; 0 = no exception.
- HWInt  in  6  hardware interrupt lines [7:2], level-sensitive.
- WE  in  1  `mtc0` write enable.
- EXLSet  in  1  exception entry strobe; the top level ties it to IntReq.
- EXLClr  in  1  `eret` strobe; clears EXL.
- IntReq  out  1  combinational interrupt/exception request.
- EPC  out  32  current EPC register value.
- dout  out  32  combinational read data selected by A1.

## Operation
- Register map:
  - 12 = SR: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - 13 = Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - 14 = EPC.
  - 15 = PRId, constant 32'h2018_1202.
  - Every other number reads 0 and ignores writes.
- Request conditions:
  - Interrupt = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
  - Exception = (ExcCode != 0) & !SR.EXL.
  - IntReq = !reset & (Interrupt | Exception).
- Delay-slot detection: BD_now = 1 when `instr` is any of:
  - beq (op 04), bne (05), blez (06), bgtz (07);
  - REGIMM (op 01);
  - j (02), jal (03);
  - jr / jalr (op 00, funct 08 / 09).
- On a clock edge with EXLSet=1:
  - SR.EXL <= 1;
  - Cause.BD <= BD_now;
  - Cause.ExcCode <= Interrupt ? 0 : ExcCode;
  - EPC <= BD_now ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}.
- Interrupt priority: a pending interrupt beats a simultaneous exception. The top level already forces ExcCode=0 when any HWInt bit is set.
- Else if EXLClr=1: SR.EXL <= 0.
- `mtc0` (WE=1):
  - A2=12 writes SR: IM, EXL and IE from din[15:10], din[1], din[0].
  - A2=14 writes EPC: din with bits [1:0] forced to 0.
  - A2=13 and A2=15 are read-only.
  - A `mtc0` that coincides with EXLSet is discarded; exception entry wins on all fields.
- Cause.IP <= HWInt on every non-reset edge, regardless of masks.
- dout = register selected by A1, combinational. A write is visible on the cycle after the edge; there is no same-cycle bypass.

## Timing
- Reset edge clears SR, Cause and EPC to 0. While reset=1: IntReq=0, EPC=0, dout=0 except PRId.
- IntReq has zero latency from HWInt, ExcCode and SR. The state update happens at the same edge at which the pipeline flushes.
- After entry, EXL=1 masks further requests starting the next cycle, until an edge with EXLClr=1.
- EXLSet and EXLClr in the same cycle: EXLSet wins and EXL stays 1.
- Holding HWInt after `eret` with IE=1 and the IM bit set re-raises IntReq the cycle after EXL clears.

## Test plan
- Reset, then read A1=12/13/14/15 → 0, 0, 0, 32'h2018_1202; IntReq=0 even with HWInt=6'h3F.
- `mtc0` SR=32'h0000_FC01, then HWInt[2]=1 with PC=32'h0000_3010 and instr=addu → IntReq=1 same cycle. After the edge: EXL=1, Cause=32'h0000_0400, EPC=32'h0000_3010, IntReq=0.
- With EXL=0, ExcCode=5'd4 at PC=32'h0000_3024 and instr=beq → IntReq=1. After the edge: Cause[31]=1, Cause[6:2]=4, EPC=32'h0000_3020.
- IE=0, IM=6'h3F, HWInt=6'h01 → IntReq=0 and Cause.IP=6'h01 after one edge. Then ExcCode=5'd10 → IntReq=1.
- EXL=1 with EXLClr=1 while HWInt is held → EXL=0 after the edge, IntReq=1 the next cycle. With EXLSet and EXLClr asserted together, EXL stays 1.
- WE=1, A2=14, din=32'h0000_4183 together with EXLSet=1 → EPC takes the exception PC, not din. With WE alone the next cycle → EPC=32'h0000_4180.
